// File: rtl/draw_image.sv
// rtl/draw_image.sv - overlays a ROM-backed image on the VGA pixel stream, 2-cycle pipeline
module draw_image #(
    parameter int          IMG_W     = 48,
    parameter int          IMG_H     = 64,
    parameter int          ADDR_W    = 12,
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    parameter logic [10:0] RST_X     = 11'd0,
    parameter logic [10:0] RST_Y     = 11'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       hcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic [10:0]       vcount_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic              pos_valid,
    output logic              pos_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [10:0]       hcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic [10:0]       vcount_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t state_q, state_d;
    logic [10:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic [10:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;

    logic [10:0] hcount_s1_q, vcount_s1_q;
    logic        hsync_s1_q, hblnk_s1_q, vsync_s1_q, vblnk_s1_q;
    logic [11:0] rgb_s1_q;
    logic        in_img_q, in_img_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic [10:0] hcount_out_q, vcount_out_q;
    logic        hsync_out_q, hblnk_out_q, vsync_out_q, vblnk_out_q;
    logic [11:0] rgb_out_q, rgb_out_d;

    logic signed [11:0] rel_x, rel_y;
    logic               in_x, in_y, frame_start;

    // Position updates are held back until frame start so the image never tears.
    always_comb begin
        state_d     = state_q;
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
        case (state_q)
            IDLE: begin
                if (pos_valid) begin
                    pend_x_d = xpos;
                    pend_y_d = ypos;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    act_x_d = pend_x_q;
                    act_y_d = pend_y_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Signed offsets keep positions near 2047 from wrapping into false hits.
    always_comb begin
        rel_x    = $signed({1'b0, hcount_in}) - $signed({1'b0, act_x_q});
        rel_y    = $signed({1'b0, vcount_in}) - $signed({1'b0, act_y_q});
        in_x     = !rel_x[11] && (rel_x[10:0] < 11'(IMG_W));
        in_y     = !rel_y[11] && (rel_y[10:0] < 11'(IMG_H));
        in_img_d = in_x && in_y && !hblnk_in && !vblnk_in;
        rom_addr_d = '0;
        if (in_img_d) begin
            rom_addr_d = ADDR_W'(rel_y[10:0]) * ADDR_W'(IMG_W) + ADDR_W'(rel_x[10:0]);
        end
    end

    always_comb begin
        rgb_out_d = rgb_s1_q;
        if (hblnk_s1_q || vblnk_s1_q) begin
            rgb_out_d = 12'h000;
        end else if (in_img_q && (rom_data != KEY_COLOR)) begin
            rgb_out_d = rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            act_x_q      <= RST_X;
            act_y_q      <= RST_Y;
            pend_x_q     <= 11'd0;
            pend_y_q     <= 11'd0;
            hcount_s1_q  <= 11'd0;
            vcount_s1_q  <= 11'd0;
            hsync_s1_q   <= 1'b0;
            hblnk_s1_q   <= 1'b0;
            vsync_s1_q   <= 1'b0;
            vblnk_s1_q   <= 1'b0;
            rgb_s1_q     <= 12'h000;
            in_img_q     <= 1'b0;
            rom_addr_q   <= '0;
            hcount_out_q <= 11'd0;
            vcount_out_q <= 11'd0;
            hsync_out_q  <= 1'b0;
            hblnk_out_q  <= 1'b0;
            vsync_out_q  <= 1'b0;
            vblnk_out_q  <= 1'b0;
            rgb_out_q    <= 12'h000;
        end else begin
            state_q      <= state_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            hcount_s1_q  <= hcount_in;
            vcount_s1_q  <= vcount_in;
            hsync_s1_q   <= hsync_in;
            hblnk_s1_q   <= hblnk_in;
            vsync_s1_q   <= vsync_in;
            vblnk_s1_q   <= vblnk_in;
            rgb_s1_q     <= rgb_in;
            in_img_q     <= in_img_d;
            rom_addr_q   <= rom_addr_d;
            hcount_out_q <= hcount_s1_q;
            vcount_out_q <= vcount_s1_q;
            hsync_out_q  <= hsync_s1_q;
            hblnk_out_q  <= hblnk_s1_q;
            vsync_out_q  <= vsync_s1_q;
            vblnk_out_q  <= vblnk_s1_q;
            rgb_out_q    <= rgb_out_d;
        end
    end

    assign pos_ready  = (state_q == IDLE);
    assign rom_addr   = rom_addr_q;
    assign hcount_out = hcount_out_q;
    assign vcount_out = vcount_out_q;
    assign hsync_out  = hsync_out_q;
    assign hblnk_out  = hblnk_out_q;
    assign vsync_out  = vsync_out_q;
    assign vblnk_out  = vblnk_out_q;
    assign rgb_out    = rgb_out_q;

endmodule

// File: doc/draw_image.md
Name: draw_image

Overview:
- Pixel-pipeline stage directly downstream of the VGA timing generator.
- Consumes hcount/vcount/sync/blank plus a background colour, and overlays an IMG_W x IMG_H image held in an external synchronous ROM at position (xpos, ypos).
- Forwards the timing signals delayed to stay aligned with the produced colour.
- Position updates are accepted via a valid/ready handshake and applied only at frame start, so the image never tears.

Parameters:
- IMG_W, 48, image width in pixels
- IMG_H, 64, image height in pixels
- ADDR_W, 12, ROM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
- KEY_COLOR, 12'hF0F, transparent colour; ROM pixels equal to it show the background
- RST_X, 0, active x position after reset
- RST_Y, 0, active y position after reset

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset
- hcount_in  in  11  horizontal pixel counter
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- vcount_in  in  11  vertical line counter
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  background colour {R4,G4,B4}
- xpos  in  11  requested image left edge
- ypos  in  11  requested image top edge
- pos_valid  in  1  position request valid
- pos_ready  out  1  block can accept a position
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  12  ROM pixel; valid exactly 1 cycle after rom_addr
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  timing signals delayed by 2 cycles
- rgb_out  out  12  composited colour

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - all timing outputs, rgb_out and rom_addr = 0;
  - pos_ready = 1;
  - active position = (RST_X, RST_Y);
  - pending flag cleared;
  - stage-1 in-image flag = 0.
- Latency: exactly 2 cycles on every path, in_x at cycle t produces out_x at t+2.
  - Stage 1 registers the timing inputs, rgb_in, the in-image flag and rom_addr.
  - Stage 2 registers the timing outputs and rgb_out, using rom_data.
- Geometry in stage 1:
  - rel_x = hcount_in - act_x and rel_y = vcount_in - act_y, computed as 12-bit signed.
  - in_img = (0 <= rel_x < IMG_W) && (0 <= rel_y < IMG_H) && !hblnk_in && !vblnk_in.
  - Rectangle is half-open: column act_x+IMG_W and row act_y+IMG_H are outside.
- ROM address:
  - rom_addr = rel_y*IMG_W + rel_x, truncated to ADDR_W, when in_img; otherwise 0.
  - The multiply is by a constant; it must not add a cycle.
- Composite in stage 2:
  - rgb_out = 0 when the stage-1 hblnk or vblnk is set.
  - Otherwise rgb_out = rom_data when in_img_d and rom_data != KEY_COLOR.
  - Otherwise rgb_out = rgb_in delayed by 1 cycle.
- Clipping: an image partially beyond the visible area is clipped by the blank terms. act_x/act_y up to 2047 are legal, and the signed rel_x/rel_y prevent wrap-around false hits.
- Position FSM (two states):
  - IDLE, pos_ready=1:
    - pos_valid=1 captures xpos/ypos into pending and goes to PENDING.
  - PENDING, pos_ready=0:
    - On frame start (hcount_in==0 && vcount_in==0), copy pending into the active position and return to IDLE.
    - The new position affects the pixel at (0,0) of that same frame, since act_* is updated combinationally-before-register? No: the active position is registered. It therefore takes effect from the next cycle, where pixel (0,0) is in blanking-free row 0. The compare for pixel (0,0) itself uses the old position.
  - pos_valid while in PENDING is ignored; no overwrite.
  - Capture in IDLE during a frame-start cycle goes to pending. It is applied at the next frame start, never mid-frame.
- Reset asserted mid-frame: the pending request is discarded and outputs are forced to 0 on the next edge. After rst deassertion the pipeline refills, and outputs are valid 2 cycles later.

Test Plan:
- Reset, then free-run timing with act=(0,0) and ROM data = address -> pixel (0,0) visible at t+2 with rgb_out=12'h000; pixel (5,1) gives rom_addr=53 and rgb_out=12'h035.
- Handshake xpos=100, ypos=200 mid-frame -> pos_ready drops the next cycle and the image stays at the old position for the rest of the frame. At the next (0,0) pos_ready rises, and the image spans columns 100..147 and rows 200..263 exactly.
- Second pos_valid while PENDING with xpos=300 -> ignored; the applied position remains 100.
- ROM returns KEY_COLOR 12'hF0F at one in-image pixel with rgb_in=12'h123 -> rgb_out=12'h123 there; neighbouring pixels show the ROM value.
- xpos=780 on an 800-wide active area -> pixels 780..799 drawn, nothing drawn during hblank, no wrap to column 0. ypos=2040 -> image never drawn.
- Timing alignment: hsync_in/vblnk_in edges appear on the outputs exactly 2 cycles later. Reset pulse mid-line -> all outputs 0, pos_ready=1, pending cleared.
